// File: rtl/multdiv_unit.sv
// Multi-cycle signed 32-bit multiply/divide unit beside the execute stage.
// Radix-4 Booth multiply (16 iterations), non-restoring divide (32 iterations).
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [65:0] prod, prod_nxt;
    logic [33:0] booth_add, acc_sum;
    logic [32:0] prod_hi;
    logic [33:0] rem, rem_sh, rem_nxt;
    logic [31:0] quo, quo_nxt, dvsr;
    logic        qsign;
    logic        accept;
    logic        div_zero;
    logic [31:0] abs_a, abs_b;

    assign accept   = (state == S_IDLE) || (state == S_DONE);
    assign div_zero = (data_operandB == 32'd0);
    assign abs_a    = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
    assign abs_b    = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

    // Product register layout: {acc[32:0], multiplier[31:0], booth_extra_bit}.
    always_comb begin
        booth_add = 34'd0;
        case (prod[2:0])
            3'b001, 3'b010: booth_add = {{2{mcand[31]}}, mcand};
            3'b011:         booth_add = {mcand[31], mcand, 1'b0};
            3'b100:         booth_add = 34'd0 - {mcand[31], mcand, 1'b0};
            3'b101, 3'b110: booth_add = 34'd0 - {{2{mcand[31]}}, mcand};
            default:        booth_add = 34'd0;
        endcase
        acc_sum  = {prod[65], prod[65:33]} + booth_add;
        prod_nxt = {acc_sum[33], acc_sum, prod[32:2]};
    end

    // The 64-bit product ends up in prod[64:1]; overflow if bits 63..31 disagree.
    assign prod_hi = prod_nxt[64:32];

    always_comb begin
        rem_sh  = {rem[32:0], quo[31]};
        rem_nxt = rem[33] ? (rem_sh + {2'b00, dvsr}) : (rem_sh - {2'b00, dvsr});
        quo_nxt = {quo[30:0], ~rem_nxt[33]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (ctrl_MULT)     state_nxt = S_MULT;
                else if (ctrl_DIV) state_nxt = div_zero ? S_DONE : S_DIV;
                else               state_nxt = S_IDLE;
            end
            S_MULT:  if (cnt == 5'd15) state_nxt = S_DONE;
            S_DIV:   if (cnt == 5'd31) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state == S_MULT) || (state == S_DIV);
        data_resultRDY = (state == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt            <= 5'd0;
            mcand          <= 32'd0;
            prod           <= 66'd0;
            rem            <= 34'd0;
            quo            <= 32'd0;
            dvsr           <= 32'd0;
            qsign          <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (ctrl_MULT) begin
                        mcand <= data_operandA;
                        prod  <= {33'd0, data_operandB, 1'b0};
                        cnt   <= 5'd0;
                    end else if (ctrl_DIV) begin
                        if (div_zero) begin
                            data_result    <= 32'd0;
                            data_exception <= 1'b1;
                        end else begin
                            quo   <= abs_a;
                            dvsr  <= abs_b;
                            rem   <= 34'd0;
                            qsign <= data_operandA[31] ^ data_operandB[31];
                            cnt   <= 5'd0;
                        end
                    end
                end
                S_MULT: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        data_result    <= prod_nxt[32:1];
                        data_exception <= !((prod_hi == '0) || (prod_hi == '1));
                    end
                end
                S_DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 5'd1;
                    // A positive quotient with bit 31 set only arises from 0x80000000 / -1.
                    if (cnt == 5'd31) begin
                        data_result    <= qsign ? (32'd0 - quo_nxt) : quo_nxt;
                        data_exception <= ~qsign & quo_nxt[31];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Multi-cycle signed 32-bit multiply/divide unit that sits beside the processor's execute stage. The execute stage issues `mul`/`div` operands with a one-cycle start pulse, stalls its pipeline on `busy`, and consumes the registered result when `data_resultRDY` pulses. Multiply uses radix-4 modified Booth recoding over 16 iterations. Divide uses non-restoring division over 32 iterations, with sign correction.

## Interface

Parameters:
- none (datapath fixed at 32 bits)

Ports:
- `clock`  in  1  single master clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low; clears all state while low
- `data_operandA`  in  32  multiplicand / dividend (two's complement)
- `data_operandB`  in  32  multiplier / divisor (two's complement)
- `ctrl_MULT`  in  1  start-multiply pulse, sampled on rising edge
- `ctrl_DIV`  in  1  start-divide pulse, sampled on rising edge
- `data_result`  out  32  product low word / quotient; held until next start
- `data_exception`  out  1  overflow or divide-by-zero flag, qualified by `data_resultRDY`
- `data_resultRDY`  out  1  one-cycle pulse: result valid
- `busy`  out  1  high while an operation is in flight (MULT or DIV state)

## Operation

- States: IDLE, MULT, DIV, DONE. Reset (`reset`=0) forces IDLE, counter=0, and all outputs to 0, regardless of clock.
- IDLE/DONE + `ctrl_MULT`=1 at edge E0:
  - latch A and B into internal registers;
  - clear the 66-bit Booth product register and the counter;
  - go to MULT.
- IDLE/DONE + `ctrl_DIV`=1 (with `ctrl_MULT`=0) at E0:
  - latch |A| and |B|, and the quotient sign (A[31]^B[31]);
  - go to DIV.
  - If B==0, go directly to DONE instead.
- Both starts high in the same cycle: MULT wins, and DIV is ignored.
- Any start seen while in MULT or DIV is ignored. The caller must hold the pipeline on `busy`.
- MULT: each edge consumes 3 multiplier bits. It adds 0 or ±1× or ±2× the multiplicand, then arithmetic-shifts right by 2. The counter increments each edge. After the 16th iteration, go to DONE.
- DIV: each edge performs one non-restoring step (shift, then add or subtract by remainder sign) and sets one quotient bit. After 32 iterations, go to DONE. Quotient negation is applied when the DONE registers are loaded.
- Result rules:
  - Multiply: `data_result` = product[31:0]. `data_exception`=1 iff product[63:31] is not all zeros and not all ones.
  - Divide: signed, truncate toward zero; the remainder is discarded.
  - Divide, B==0: result=0, exception=1.
  - Divide, A=0x80000000, B=0xFFFFFFFF: result=0x80000000, exception=1.
- DONE lasts exactly one cycle: `data_resultRDY`=1 and `busy`=0. It returns to IDLE, or goes to MULT/DIV if a new start is sampled.
- `data_result` and `data_exception` hold their values until the next DONE load or reset.

## Timing

- Multiply: start sampled at E0. Iterations on E1–E16; DONE and outputs loaded at E16. `data_resultRDY` is high during the cycle E16–E17. Latency is 16 cycles.
- Divide: iterations on E1–E32; `data_resultRDY` is high during E32–E33. Latency is 32 cycles.
- Divide by zero: DONE is loaded at E0 itself; `data_resultRDY` is high during E0–E1. Latency is 1 cycle.
- `busy` is high from just after E0 until the DONE edge. It is low in IDLE and DONE.
- Back-to-back: a start sampled in the DONE cycle is accepted. The old result is still visible for that cycle and is replaced at the next DONE.
- Reset mid-operation: the operation is abandoned, and no `data_resultRDY` is issued. After release, the unit is in IDLE and the next start behaves as from cold.
- No combinational path from the operand or ctrl inputs to any output.

## Test plan

- Multiply 7 × −3: `ctrl_MULT` pulse → `data_resultRDY` exactly 16 cycles later; result 0xFFFFFFEB, exception 0, `busy` high for 16 cycles.
- Multiply overflow 0x00010000 × 0x00010000 → result 0x00000000, exception 1. Then 0x7FFFFFFF × 1 → 0x7FFFFFFF, exception 0.
- Divide −7 ÷ 2 → RDY 32 cycles later, result 0xFFFFFFFD (−3), exception 0. Then 100 ÷ −7 → 0xFFFFFFF2 (−14).
- Divide 5 ÷ 0 → RDY the cycle after start, result 0, exception 1. Divide 0x80000000 ÷ −1 → 0x80000000, exception 1.
- Starts during `busy` are ignored: issue MULT 3×4, then pulse `ctrl_DIV` at cycle 5 → single RDY at cycle 16 with result 12. Simultaneous MULT+DIV with 6, 3 → result 18.
- Reset low at cycle 10 of a divide → all outputs 0 immediately, no RDY. After release, MULT 2×2 → result 4 at +16 cycles. A back-to-back start in the DONE cycle gives a second RDY 16 cycles later.
